multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle combinational control unit.
- FSM sequences fetch, decode, execute, memory and writeback over several clocks, with ready/done handshakes to instruction memory, data memory and a multi-cycle multiply/divide unit.
- Latches a precise exception cause and halts stickily.
- Sits between the IR/PC datapath and the register file, ALU and memories.

Parameters:
- OP_CODE_WIDTH, 4, opcode field width
- FUNCTION_CODE_WIDTH, 4, ALU function field width
- ALU_CONTROL_WIDTH, 4, ALU select width (>= FUNCTION_CODE_WIDTH)
- BRANCH_CONTROL_WIDTH, 2, branch code width
- WAIT_LIMIT, 15, max cycles any handshake wait may last before a timeout halt

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op_code  in  OP_CODE_WIDTH  opcode from IR
- func_code  in  FUNCTION_CODE_WIDTH  function field from IR
- inst_mem_ready  in  1  instruction word valid
- data_mem_ready  in  1  data access complete
- alu_done  in  1  multi-cycle MUL/DIV complete
- inst_memory_exception, data_memory_exception, alu_exception  in  1 each  fault flags
- inst_mem_rd, ir_write, pc_write  out  1  fetch controls
- data_mem_rd, mem_wrt  out  1  data memory strobes
- alu_start  out  1  one-cycle MUL/DIV launch pulse
- alu_control  out  ALU_CONTROL_WIDTH  ALU operation
- alu_a_src, alu_b_src, reg_wr_src, write_reg, write_r0, jump  out  1  datapath controls
- branch  out  BRANCH_CONTROL_WIDTH  11 BLT, 10 BGT, 01 BEQ
- halt  out  1  processor stopped (sticky)
- exception_cause  out  3  000 none/HALT instr, 001 alu, 010 data mem, 011 inst mem, 100 illegal opcode, 101 timeout

Behaviour:
- Opcodes: ALU 0000, LW 1000, SW 1011, BLT 0100, BGT 0101, BEQ 0110, JMP 1100, HALT 1111.
- Function codes: ADD 1111, SUB 1110, AND 1101, OR 1100, MUL 0001, DIV 0010, SLL 1010, SLR 1011, ROL 1001, ROR 1000.
- Reset (async, reset_n low):
  - state = FETCH; all outputs 0; exception_cause = 000; wait counter 0.
  - Reset asserted mid-operation aborts immediately; no strobe survives.
- States: FETCH, DECODE, EXEC, MD_WAIT, MEM, WB, HALTED. Outputs are Moore-decoded from state plus latched op/func. Unlisted outputs are 0.
- FETCH:
  - inst_mem_rd = 1.
  - On inst_mem_ready: ir_write = 1 and pc_write = 1 that cycle, go to DECODE.
- DECODE:
  - Latch op_code/func_code into internal registers; all later states use the latched copy.
  - HALT goes to HALTED with cause 000.
  - Unlisted opcode goes to HALTED with cause 100.
  - Otherwise go to EXEC.
- EXEC:
  - ALU: alu_control = func. alu_b_src = 1 for shifts/rotates. MUL/DIV assert alu_start for exactly one cycle and go to MD_WAIT; all others go to WB.
  - LW/SW: alu_a_src = 1, alu_control = ADD, go to MEM.
  - Branches: branch code for one cycle, go to FETCH.
  - JMP: jump = 1 for one cycle, go to FETCH.
- MD_WAIT: hold alu_control; on alu_done go to WB.
- MEM:
  - LW holds data_mem_rd and alu_a_src; on data_mem_ready go to WB.
  - SW holds mem_wrt and alu_a_src; on data_mem_ready go to FETCH.
- WB:
  - write_reg = 1 for one cycle.
  - write_r0 = 1 for MUL/DIV; reg_wr_src = 1 for LW.
  - alu_control is held from EXEC; go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MD_WAIT and MEM; increments each cycle the awaited ready/done is low.
  - Reaching WAIT_LIMIT with ready still low goes to HALTED with cause 101.
  - Ready arriving on the limit cycle wins.
- Exceptions:
  - Any exception input high in a non-HALTED state gives HALTED next cycle.
  - Cause priority: inst 011 > data 010 > alu 001.
  - In that same cycle ir_write, pc_write, mem_wrt, write_reg, write_r0, branch and jump are forced 0.
  - Exception beats ready/done on the same cycle.
- HALTED: halt = 1 and all strobes 0; exception_cause is held; exits only via reset_n.

Test Plan:
- Reset: reset_n low mid-MEM of SW -> mem_wrt drops asynchronously, state FETCH, halt 0, cause 000.
- ADD with ready=1 -> FETCH, DECODE, EXEC, WB over 4 cycles; write_reg pulses once in WB; alu_control 1111.
- MUL with alu_done 3 cycles after start -> alu_start single pulse; WB has write_reg = 1, write_r0 = 1; total 7 cycles.
- LW with data_mem_ready 2 cycles late -> data_mem_rd held 3 cycles; WB has reg_wr_src = 1.
- SW with data_mem_ready never asserted, WAIT_LIMIT 15 -> halt after 15 wait cycles, cause 101, mem_wrt 0.
- data_memory_exception pulse during SW MEM together with data_mem_ready -> mem_wrt forced 0 that cycle, cause 010, halt sticky.
- Opcode 0011 -> HALTED from DECODE, cause 100.
- BEQ -> branch 01 for one cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback with
// ready/done handshakes, bounded waits and a sticky precise-exception halt.
module multicycle_control #(
  parameter int OP_CODE_WIDTH        = 4,
  parameter int FUNCTION_CODE_WIDTH  = 4,
  parameter int ALU_CONTROL_WIDTH    = 4,
  parameter int BRANCH_CONTROL_WIDTH = 2,
  parameter int WAIT_LIMIT           = 15
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [OP_CODE_WIDTH-1:0]        op_code,
  input  logic [FUNCTION_CODE_WIDTH-1:0]  func_code,
  input  logic                            inst_mem_ready,
  input  logic                            data_mem_ready,
  input  logic                            alu_done,
  input  logic                            inst_memory_exception,
  input  logic                            data_memory_exception,
  input  logic                            alu_exception,
  output logic                            inst_mem_rd,
  output logic                            ir_write,
  output logic                            pc_write,
  output logic                            data_mem_rd,
  output logic                            mem_wrt,
  output logic                            alu_start,
  output logic [ALU_CONTROL_WIDTH-1:0]    alu_control,
  output logic                            alu_a_src,
  output logic                            alu_b_src,
  output logic                            reg_wr_src,
  output logic                            write_reg,
  output logic                            write_r0,
  output logic                            jump,
  output logic [BRANCH_CONTROL_WIDTH-1:0] branch,
  output logic                            halt,
  output logic [2:0]                      exception_cause
);

  localparam logic [OP_CODE_WIDTH-1:0] OP_ALU  = OP_CODE_WIDTH'(4'b0000);
  localparam logic [OP_CODE_WIDTH-1:0] OP_LW   = OP_CODE_WIDTH'(4'b1000);
  localparam logic [OP_CODE_WIDTH-1:0] OP_SW   = OP_CODE_WIDTH'(4'b1011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_BLT  = OP_CODE_WIDTH'(4'b0100);
  localparam logic [OP_CODE_WIDTH-1:0] OP_BGT  = OP_CODE_WIDTH'(4'b0101);
  localparam logic [OP_CODE_WIDTH-1:0] OP_BEQ  = OP_CODE_WIDTH'(4'b0110);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JMP  = OP_CODE_WIDTH'(4'b1100);
  localparam logic [OP_CODE_WIDTH-1:0] OP_HALT = OP_CODE_WIDTH'(4'b1111);

  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_ADD = FUNCTION_CODE_WIDTH'(4'b1111);
  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_MUL = FUNCTION_CODE_WIDTH'(4'b0001);
  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_DIV = FUNCTION_CODE_WIDTH'(4'b0010);
  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_SLL = FUNCTION_CODE_WIDTH'(4'b1010);
  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_SLR = FUNCTION_CODE_WIDTH'(4'b1011);
  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_ROL = FUNCTION_CODE_WIDTH'(4'b1001);
  localparam logic [FUNCTION_CODE_WIDTH-1:0] FN_ROR = FUNCTION_CODE_WIDTH'(4'b1000);

  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = ALU_CONTROL_WIDTH'(FN_ADD);

  localparam logic [BRANCH_CONTROL_WIDTH-1:0] BR_BLT = BRANCH_CONTROL_WIDTH'(2'b11);
  localparam logic [BRANCH_CONTROL_WIDTH-1:0] BR_BGT = BRANCH_CONTROL_WIDTH'(2'b10);
  localparam logic [BRANCH_CONTROL_WIDTH-1:0] BR_BEQ = BRANCH_CONTROL_WIDTH'(2'b01);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MD_WAIT = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALTED  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'b000,
    CAUSE_ALU     = 3'b001,
    CAUSE_DMEM    = 3'b010,
    CAUSE_IMEM    = 3'b011,
    CAUSE_ILLEGAL = 3'b100,
    CAUSE_TIMEOUT = 3'b101
  } cause_t;

  state_t                         state_q, state_d;
  cause_t                         cause_q, cause_d, exc_cause;
  cnt_t                           wait_cnt_q;
  logic [OP_CODE_WIDTH-1:0]       op_q;
  logic [FUNCTION_CODE_WIDTH-1:0] func_q;

  logic                         is_lw, is_mem_op, is_md, is_shift;
  logic                         awaited, timeout, exc_take;
  logic [ALU_CONTROL_WIDTH-1:0] alu_sel;

  function automatic logic legal_op(input logic [OP_CODE_WIDTH-1:0] op);
    return op inside {OP_ALU, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP};
  endfunction

  // Everything past DECODE works off the latched instruction, not the live IR.
  assign is_lw     = (op_q == OP_LW);
  assign is_mem_op = is_lw || (op_q == OP_SW);
  assign is_md     = (op_q == OP_ALU) && (func_q == FN_MUL || func_q == FN_DIV);
  assign is_shift  = (op_q == OP_ALU) && (func_q inside {FN_SLL, FN_SLR, FN_ROL, FN_ROR});
  assign alu_sel   = is_mem_op ? ALU_ADD : ALU_CONTROL_WIDTH'(func_q);

  assign exc_take = (inst_memory_exception || data_memory_exception || alu_exception)
                    && (state_q != S_HALTED);

  always_comb begin
    if (inst_memory_exception)      exc_cause = CAUSE_IMEM;
    else if (data_memory_exception) exc_cause = CAUSE_DMEM;
    else                            exc_cause = CAUSE_ALU;
  end

  // Handshake being waited on in the current state; non-wait states never time out.
  always_comb begin
    case (state_q)
      S_FETCH:   awaited = inst_mem_ready;
      S_MD_WAIT: awaited = alu_done;
      S_MEM:     awaited = data_mem_ready;
      default:   awaited = 1'b1;
    endcase
  end

  assign timeout = !awaited && (wait_cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      cause_q    <= CAUSE_NONE;
      wait_cnt_q <= '0;
      op_q       <= '0;
      func_q     <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d != state_q)
        wait_cnt_q <= '0;
      else if (!awaited)
        wait_cnt_q <= wait_cnt_q + cnt_t'(1);
      if (state_q == S_DECODE) begin
        op_q   <= op_code;
        func_q <= func_code;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:   if (inst_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op_code == OP_HALT) begin
          state_d = S_HALTED;
          cause_d = CAUSE_NONE;
        end else if (!legal_op(op_code)) begin
          state_d = S_HALTED;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_ALU)  state_d = is_md ? S_MD_WAIT : S_WB;
        else if (is_mem_op)  state_d = S_MEM;
        else                 state_d = S_FETCH;
      end
      S_MD_WAIT: if (alu_done) state_d = S_WB;
      S_MEM:     if (data_mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      S_WB:      state_d = S_FETCH;
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_HALTED;
      cause_d = CAUSE_TIMEOUT;
    end
    // A fault outranks any ready/done seen in the same cycle.
    if (exc_take) begin
      state_d = S_HALTED;
      cause_d = exc_cause;
    end
  end

  always_comb begin
    inst_mem_rd = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    data_mem_rd = 1'b0;
    mem_wrt     = 1'b0;
    alu_start   = 1'b0;
    alu_control = '0;
    alu_a_src   = 1'b0;
    alu_b_src   = 1'b0;
    reg_wr_src  = 1'b0;
    write_reg   = 1'b0;
    write_r0    = 1'b0;
    jump        = 1'b0;
    branch      = '0;
    halt        = 1'b0;
    // Gating on reset_n keeps every strobe low for the whole reset pulse.
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          inst_mem_rd = 1'b1;
          ir_write    = inst_mem_ready;
          pc_write    = inst_mem_ready;
        end
        S_EXEC: begin
          if (op_q == OP_ALU) begin
            alu_control = alu_sel;
            alu_b_src   = is_shift;
            alu_start   = is_md;
          end else if (is_mem_op) begin
            alu_control = alu_sel;
            alu_a_src   = 1'b1;
          end else if (op_q == OP_BLT) begin
            branch = BR_BLT;
          end else if (op_q == OP_BGT) begin
            branch = BR_BGT;
          end else if (op_q == OP_BEQ) begin
            branch = BR_BEQ;
          end else if (op_q == OP_JMP) begin
            jump = 1'b1;
          end
        end
        S_MD_WAIT: alu_control = alu_sel;
        S_MEM: begin
          alu_a_src   = 1'b1;
          data_mem_rd = is_lw;
          mem_wrt     = !is_lw;
        end
        S_WB: begin
          write_reg   = 1'b1;
          write_r0    = is_md;
          reg_wr_src  = is_lw;
          alu_control = alu_sel;
        end
        S_HALTED: halt = 1'b1;
        default: ;
      endcase
      if (exc_take) begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        mem_wrt   = 1'b0;
        write_reg = 1'b0;
        write_r0  = 1'b0;
        jump      = 1'b0;
        branch    = '0;
      end
    end
  end

  assign exception_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction or
// fault scenario cycle by cycle against hand-computed output vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] op_code = '0;
  logic [3:0] func_code = '0;
  logic       inst_mem_ready = 1'b0, data_mem_ready = 1'b0, alu_done = 1'b0;
  logic       inst_memory_exception = 1'b0, data_memory_exception = 1'b0, alu_exception = 1'b0;
  logic       inst_mem_rd, ir_write, pc_write, data_mem_rd, mem_wrt, alu_start;
  logic [3:0] alu_control;
  logic       alu_a_src, alu_b_src, reg_wr_src, write_reg, write_r0, jump;
  logic [1:0] branch;
  logic       halt;
  logic [2:0] exception_cause;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .op_code(op_code), .func_code(func_code),
    .inst_mem_ready(inst_mem_ready), .data_mem_ready(data_mem_ready), .alu_done(alu_done),
    .inst_memory_exception(inst_memory_exception),
    .data_memory_exception(data_memory_exception), .alu_exception(alu_exception),
    .inst_mem_rd(inst_mem_rd), .ir_write(ir_write), .pc_write(pc_write),
    .data_mem_rd(data_mem_rd), .mem_wrt(mem_wrt), .alu_start(alu_start),
    .alu_control(alu_control), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .reg_wr_src(reg_wr_src), .write_reg(write_reg), .write_r0(write_r0), .jump(jump),
    .branch(branch), .halt(halt), .exception_cause(exception_cause)
  );

  always #5 clk = ~clk;

  // Output vector bit positions.
  localparam logic [21:0] IMRD  = 22'd1 << 21;
  localparam logic [21:0] IRW   = 22'd1 << 20;
  localparam logic [21:0] PCW   = 22'd1 << 19;
  localparam logic [21:0] DMRD  = 22'd1 << 18;
  localparam logic [21:0] MWRT  = 22'd1 << 17;
  localparam logic [21:0] START = 22'd1 << 16;
  localparam logic [21:0] ASRC  = 22'd1 << 11;
  localparam logic [21:0] BSRC  = 22'd1 << 10;
  localparam logic [21:0] RWSRC = 22'd1 << 9;
  localparam logic [21:0] WREG  = 22'd1 << 8;
  localparam logic [21:0] WR0   = 22'd1 << 7;
  localparam logic [21:0] JUMP  = 22'd1 << 6;
  localparam logic [21:0] HALT  = 22'd1 << 3;

  function automatic logic [21:0] ac(input logic [3:0] v);
    return {6'b0, v, 12'b0};
  endfunction
  function automatic logic [21:0] br(input logic [1:0] v);
    return {16'b0, v, 4'b0};
  endfunction
  function automatic logic [21:0] cs(input logic [2:0] v);
    return {19'b0, v};
  endfunction
  function automatic logic [21:0] outs();
    return {inst_mem_rd, ir_write, pc_write, data_mem_rd, mem_wrt, alu_start, alu_control,
            alu_a_src, alu_b_src, reg_wr_src, write_reg, write_r0, jump, branch, halt,
            exception_cause};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    op_code = '0; func_code = '0;
    inst_mem_ready = 1'b0; data_mem_ready = 1'b0; alu_done = 1'b0;
    inst_memory_exception = 1'b0; data_memory_exception = 1'b0; alu_exception = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Runs FETCH (ready at once) and DECODE; returns in the cycle after DECODE.
  task automatic fetch_decode(input logic [3:0] op, input logic [3:0] fn);
    op_code = op; func_code = fn; inst_mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== (IMRD | IRW | PCW)) begin
      bad++; $display("FAIL fetch op=%b: got=%h expected=%h", op, outs(), IMRD | IRW | PCW);
    end
    tick();
    inst_mem_ready = 1'b0;
    #1;
    total++;
    if (outs() !== 22'd0) begin
      bad++; $display("FAIL decode op=%b: got=%h expected=%h", op, outs(), 22'd0);
    end
    tick();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (outs() !== 22'd0) begin
      bad++; $display("FAIL reset_hold: got=%h expected=%h", outs(), 22'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (outs() !== IMRD) begin
      bad++; $display("FAIL reset_release: got=%h expected=%h", outs(), IMRD);
    end
    tick();
    total++;
    if (outs() !== IMRD) begin
      bad++; $display("FAIL fetch_wait: got=%h expected=%h", outs(), IMRD);
    end
  endtask

  task automatic test_add();
    fetch_decode(4'b0000, 4'b1111);
    op_code = 4'b1100; func_code = 4'b0001;  // live IR changes must be ignored
    #1;
    total++;
    if (outs() !== ac(4'hF)) begin
      bad++; $display("FAIL add_exec: got=%h expected=%h", outs(), ac(4'hF));
    end
    tick();
    total++;
    if (outs() !== (WREG | ac(4'hF))) begin
      bad++; $display("FAIL add_wb: got=%h expected=%h", outs(), WREG | ac(4'hF));
    end
    tick();
    total++;
    if (outs() !== IMRD) begin
      bad++; $display("FAIL add_refetch: got=%h expected=%h", outs(), IMRD);
    end
  endtask

  task automatic test_shift();
    fetch_decode(4'b0000, 4'b1010);
    #1;
    total++;
    if (outs() !== (ac(4'hA) | BSRC)) begin
      bad++; $display("FAIL sll_exec: got=%h expected=%h", outs(), ac(4'hA) | BSRC);
    end
    tick();
    total++;
    if (outs() !== (WREG | ac(4'hA))) begin
      bad++; $display("FAIL sll_wb: got=%h expected=%h", outs(), WREG | ac(4'hA));
    end
    tick();
  endtask

  task automatic test_mul();
    fetch_decode(4'b0000, 4'b0001);
    op_code = 4'b1111;
    #1;
    total++;
    if (outs() !== (ac(4'h1) | START)) begin
      bad++; $display("FAIL mul_exec: got=%h expected=%h", outs(), ac(4'h1) | START);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      alu_done = (i == 2);
      #1;
      total++;
      if (outs() !== ac(4'h1)) begin
        bad++; $display("FAIL mul_wait%0d: got=%h expected=%h", i, outs(), ac(4'h1));
      end
      tick();
    end
    alu_done = 1'b0;
    #1;
    total++;
    if (outs() !== (WREG | WR0 | ac(4'h1))) begin
      bad++; $display("FAIL mul_wb: got=%h expected=%h", outs(), WREG | WR0 | ac(4'h1));
    end
    tick();
    total++;
    if (outs() !== IMRD) begin
      bad++; $display("FAIL mul_refetch: got=%h expected=%h", outs(), IMRD);
    end
  endtask

  task automatic test_lw();
    fetch_decode(4'b1000, 4'b0000);
    #1;
    total++;
    if (outs() !== (ASRC | ac(4'hF))) begin
      bad++; $display("FAIL lw_exec: got=%h expected=%h", outs(), ASRC | ac(4'hF));
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      data_mem_ready = (i == 2);
      #1;
      total++;
      if (outs() !== (ASRC | DMRD)) begin
        bad++; $display("FAIL lw_mem%0d: got=%h expected=%h", i, outs(), ASRC | DMRD);
      end
      tick();
    end
    data_mem_ready = 1'b0;
    #1;
    total++;
    if (outs() !== (WREG | RWSRC | ac(4'hF))) begin
      bad++; $display("FAIL lw_wb: got=%h expected=%h", outs(), WREG | RWSRC | ac(4'hF));
    end
    tick();
  endtask

  task automatic test_branches();
    logic [3:0]  ops  [4] = '{4'b0100, 4'b0101, 4'b0110, 4'b1100};
    logic [21:0] exps [4] = '{br(2'b11), br(2'b10), br(2'b01), JUMP};
    for (int i = 0; i < 4; i++) begin
      fetch_decode(ops[i], 4'b0000);
      #1;
      total++;
      if (outs() !== exps[i]) begin
        bad++; $display("FAIL branch_exec op=%b: got=%h expected=%h", ops[i], outs(), exps[i]);
      end
      tick();
      total++;
      if (outs() !== IMRD) begin
        bad++; $display("FAIL branch_refetch op=%b: got=%h expected=%h", ops[i], outs(), IMRD);
      end
    end
  endtask

  task automatic test_limit_ready();
    do_reset();
    fetch_decode(4'b1011, 4'b0000);
    tick();
    for (int i = 0; i < 15; i++) begin
      data_mem_ready = (i == 14);
      #1;
      total++;
      if (outs() !== (ASRC | MWRT)) begin
        bad++; $display("FAIL limit_mem%0d: got=%h expected=%h", i, outs(), ASRC | MWRT);
      end
      tick();
    end
    data_mem_ready = 1'b0;
    #1;
    total++;
    if (outs() !== IMRD) begin
      bad++; $display("FAIL limit_ready_wins: got=%h expected=%h", outs(), IMRD);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    fetch_decode(4'b1011, 4'b0000);
    #1;
    total++;
    if (outs() !== (ASRC | ac(4'hF))) begin
      bad++; $display("FAIL sw_exec: got=%h expected=%h", outs(), ASRC | ac(4'hF));
    end
    tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      total++;
      if (outs() !== (ASRC | MWRT)) begin
        bad++; $display("FAIL sw_wait%0d: got=%h expected=%h", i, outs(), ASRC | MWRT);
      end
      tick();
    end
    inst_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (outs() !== (HALT | cs(3'b101))) begin
        bad++; $display("FAIL timeout_halt%0d: got=%h expected=%h", i, outs(), HALT | cs(3'b101));
      end
      tick();
    end
  endtask

  task automatic test_data_exc();
    do_reset();
    fetch_decode(4'b1011, 4'b0000);
    tick();
    #1;
    total++;
    if (outs() !== (ASRC | MWRT)) begin
      bad++; $display("FAIL dexc_mem: got=%h expected=%h", outs(), ASRC | MWRT);
    end
    data_mem_ready = 1'b1;
    data_memory_exception = 1'b1;
    #1;
    total++;
    if (outs() !== ASRC) begin
      bad++; $display("FAIL dexc_forced: got=%h expected=%h", outs(), ASRC);
    end
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (outs() !== (HALT | cs(3'b010))) begin
        bad++; $display("FAIL dexc_halt%0d: got=%h expected=%h", i, outs(), HALT | cs(3'b010));
      end
      inst_mem_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_exc_priority();
    logic [2:0] flags [3] = '{3'b111, 3'b011, 3'b001};
    logic [2:0] cause [3] = '{3'b011, 3'b010, 3'b001};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      inst_mem_ready = 1'b1;
      {inst_memory_exception, data_memory_exception, alu_exception} = flags[i];
      #1;
      total++;
      if (outs() !== IMRD) begin
        bad++; $display("FAIL exc_fetch_forced%0d: got=%h expected=%h", i, outs(), IMRD);
      end
      tick();
      clear_inputs();
      #1;
      total++;
      if (outs() !== (HALT | cs(cause[i]))) begin
        bad++; $display("FAIL exc_cause%0d: got=%h expected=%h", i, outs(), HALT | cs(cause[i]));
      end
    end
  endtask

  task automatic test_illegal_and_halt();
    do_reset();
    fetch_decode(4'b0011, 4'b0000);
    #1;
    total++;
    if (outs() !== (HALT | cs(3'b100))) begin
      bad++; $display("FAIL illegal_op: got=%h expected=%h", outs(), HALT | cs(3'b100));
    end
    do_reset();
    fetch_decode(4'b1111, 4'b0000);
    #1;
    total++;
    if (outs() !== HALT) begin
      bad++; $display("FAIL halt_op: got=%h expected=%h", outs(), HALT);
    end
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    fetch_decode(4'b1011, 4'b0000);
    tick();
    #1;
    total++;
    if (outs() !== (ASRC | MWRT)) begin
      bad++; $display("FAIL rst_sw_mem: got=%h expected=%h", outs(), ASRC | MWRT);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (outs() !== 22'd0) begin
      bad++; $display("FAIL rst_async: got=%h expected=%h", outs(), 22'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (outs() !== IMRD) begin
      bad++; $display("FAIL rst_to_fetch: got=%h expected=%h", outs(), IMRD);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_mul();
    test_lw();
    test_branches();
    test_limit_ready();
    test_timeout();
    test_data_exc();
    test_exc_priority();
    test_illegal_and_halt();
    test_reset_mid_sw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
